lsu_mem_master: RTL and testbench
=================================

# lsu_mem_master

Load/store initiator that drives the single-port word-wide data memory (async read, synchronous write, byte address on `A`) on behalf of the core datapath. It accepts one byte/half/word load or store request at a time via a valid/ready handshake, performs lane alignment and sign extension, and executes sub-word stores as read-modify-write. It returns a one-cycle response pulse and sits between the execute stage and the data memory.

## Interface

- `ADDR_W`, 32, byte address width
- `DATA_W`, 32, data width; only 32 is supported

- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  block can accept; high only in IDLE and `rst`=0
- `req_we`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal
- `req_unsigned`  in  1  loads: zero-extend instead of sign-extend
- `req_addr`  in  ADDR_W  byte address
- `req_wdata`  in  DATA_W  store data, right-justified
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_err`  out  1  valid with `resp_valid`; misaligned or illegal size
- `resp_rdata`  out  DATA_W  extended load data; 0 for stores and errors
- `mem_WE`  out  1  memory write enable
- `mem_A`  out  ADDR_W  word-aligned byte address `{addr[ADDR_W-1:2],2'b00}`
- `mem_WD`  out  DATA_W  memory write data
- `mem_RD`  in  DATA_W  memory read data, combinational from `mem_A`

## Operation

- FSM states: IDLE, ACCESS, WRITE, RESP.
- Accept when `req_valid && req_ready`; latch we, size, unsigned, addr, wdata.
- Error check at accept: size 11; half with addr[0]=1; word with addr[1:0]≠0. Error → RESP with `resp_err`=1 and no memory activity.
- Load: IDLE→ACCESS (drive `mem_A`, capture `mem_RD` at end of cycle)→RESP.
- Word store: IDLE→WRITE (`mem_WE`=1, `mem_WD`=wdata)→RESP.
- Byte/half store: IDLE→ACCESS (capture old word)→WRITE (merged word)→RESP.
- Little-endian lanes: byte lane = addr[1:0], half lane = addr[1]. Merge replaces only the addressed lane(s) with wdata[7:0] or wdata[15:0].
- Load extract: shift the selected lane to bit 0. Sign-extend from bit 7 or 15 unless `req_unsigned`. Word loads pass through.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE. There is no response backpressure.
- `mem_WE`=1 only in WRITE. `mem_A` holds the latched aligned address in every non-IDLE state and 0 in IDLE. `mem_WD` is 0 outside WRITE.
- `req_*` inputs are ignored when `req_ready`=0.

## Timing

- Accept edge = E0.
- Load: `resp_valid` high in cycle after E1. Latency is 2 cycles.
- Word store: memory written at E1; `resp_valid` after E1. Latency is 2 cycles.
- Sub-word store: read in ACCESS, write at E2, `resp_valid` after E2. Latency is 3 cycles.
- Error: `resp_valid` after E0. Latency is 1 cycle.
- `req_ready` returns high the cycle after RESP, so back-to-back throughput is one request per latency+1 cycles.
- Reset (`rst`=1, async, any state): state→IDLE immediately. `req_ready`, `resp_valid`, `resp_err`, `mem_WE` = 0; `resp_rdata`, `mem_A`, `mem_WD` = 0; latched request cleared.
  - Reset mid-WRITE drops `mem_WE` combinationally, so no write occurs at the next edge.
  - The in-flight request is dropped with no response.

## Structure

- Package `lsu_pkg`: size encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`), FSM state enum, and a misalignment-check function.
- One combinational sub-module, `lsu_lane_align`, contains load extract/extend and store merge. It takes addr[1:0], size, unsigned, old word and wdata, and outputs the load result and the merged word.
- FSM, request latch and memory drive stay in the top module.

## Test plan

Memory model initialised to 0, except the word at byte address 28 = 0x00000020.

- Reset: hold `rst`=1 → `req_ready`=0, `resp_valid`=0, `mem_WE`=0. Release `rst` → `req_ready`=1 the next cycle.
- Word load at addr 28 → `resp_valid` 2 cycles after accept, `resp_rdata`=0x00000020, `mem_WE` never high.
- Word store 0xDEADBEEF at addr 0 → `mem_WE` high exactly one cycle with `mem_WD`=0xDEADBEEF. Then:
  - byte load signed at addr 3 → 0xFFFFFFDE
  - byte load unsigned at addr 3 → 0x000000DE
  - half load signed at addr 2 → 0xFFFFDEAD
- Byte store 0x55 at addr 1 (memory holds 0xDEADBEEF) → ACCESS then WRITE with `mem_WD`=0xDEAD55EF, `resp_valid` 3 cycles after accept. A following word load returns 0xDEAD55EF.
- Misaligned and illegal requests: half load at addr 1, word store at addr 2, and size 11 → `resp_err`=1 and `resp_rdata`=0 one cycle after accept; `mem_WE`=0 and `mem_A`=0 throughout.
- Assert `rst` during the WRITE state of a byte store of 0x11 at addr 0 → `mem_WE` falls without waiting for a clock edge. Word 0 is unchanged, there is no `resp_valid`, and the FSM is in IDLE after `rst` is released.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store memory master.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // True when the request cannot be performed: illegal size or an address
  // that is not naturally aligned for the access size.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane steering: load extract/extend and sub-word store merge.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        addr_lo_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [DATA_W-1:0] old_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] load_o,
  output logic [DATA_W-1:0] merged_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [4:0]  b_base;
  logic [4:0]  h_base;

  assign b_base = {addr_lo_i, 3'b000};
  assign h_base = {addr_lo_i[1], 4'b0000};

  // Select the addressed lane for loads and overlay new data for stores.
  always_comb begin
    lane_b   = old_i[b_base +: 8];
    lane_h   = old_i[h_base +: 16];
    load_o   = old_i;
    merged_o = old_i;
    case (size_i)
      SZ_BYTE: begin
        load_o                = {{(DATA_W-8){~unsigned_i & lane_b[7]}}, lane_b};
        merged_o[b_base +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        load_o                 = {{(DATA_W-16){~unsigned_i & lane_h[15]}}, lane_h};
        merged_o[h_base +: 16] = wdata_i[15:0];
      end
      default: begin
        load_o   = old_i;
        merged_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator for a single-port word-wide data memory.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_WE,
  output logic [ADDR_W-1:0] mem_A,
  output logic [DATA_W-1:0] mem_WD,
  input  logic [DATA_W-1:0] mem_RD
);

  state_e              state_q, state_d;
  logic                we_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   word_q;
  logic                err_q;

  logic                accept;
  logic                acc_err;
  logic [ADDR_W-1:0]   aligned_a;
  logic [DATA_W-1:0]   load_data;
  logic [DATA_W-1:0]   merged;

  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign acc_err   = misaligned(req_size, req_addr[1:0]);
  assign aligned_a = {addr_q[ADDR_W-1:2], 2'b00};

  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .addr_lo_i  (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .old_i      (word_q),
    .wdata_i    (wdata_q),
    .load_o     (load_data),
    .merged_o   (merged)
  );

  // FSM state register; reset forces IDLE immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Request latch on accept and old-word capture at the end of ACCESS.
  // Errored requests latch a zero address so the bus stays quiet in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        addr_q  <= acc_err ? '0 : req_addr;
        wdata_q <= req_wdata;
        err_q   <= acc_err;
      end
      if (state_q == ST_ACCESS) word_q <= mem_RD;
    end
  end

  // Next-state sequencing and memory/response drive.
  always_comb begin
    state_d    = state_q;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_WE     = 1'b0;
    mem_A      = '0;
    mem_WD     = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (acc_err)                state_d = ST_RESP;
          else if (!req_we)           state_d = ST_ACCESS;
          else if (req_size == SZ_WORD) state_d = ST_WRITE;
          else                        state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_A   = aligned_a;
        state_d = we_q ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        mem_A   = aligned_a;
        mem_WE  = 1'b1;
        mem_WD  = merged;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        mem_A      = aligned_a;
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (we_q || err_q) ? '0 : load_data;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a small word memory model.
module tb_lsu_mem_master;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_WE;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic [31:0] mem_RD;

  logic [31:0] mem [0:15];

  int n_cmp = 0;
  int n_bad = 0;

  lsu_mem_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_rdata   (resp_rdata),
    .mem_WE       (mem_WE),
    .mem_A        (mem_A),
    .mem_WD       (mem_WD),
    .mem_RD       (mem_RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_RD = mem[mem_A[5:2]];

  always @(posedge clk) begin
    if (mem_WE) mem[mem_A[5:2]] <= mem_WD;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request from a negedge and watch five cycles after accept.
  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_k, input logic exp_err, input logic [31:0] exp_rdata,
                        input int exp_wecnt, input logic [31:0] exp_wd, input logic [31:0] exp_aor);
    int          k_resp;
    int          n_resp;
    int          we_cnt;
    logic [31:0] last_wd;
    logic [31:0] a_or;
    logic        err_s;
    logic [31:0] rdata_s;
    k_resp  = -1;
    n_resp  = 0;
    we_cnt  = 0;
    last_wd = 32'h0;
    a_or    = 32'h0;
    err_s   = 1'b0;
    rdata_s = 32'h0;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    #1;
    check({tag, ".ready"}, {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wdata = 32'hA5A5A5A5;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      a_or = a_or | mem_A;
      if (mem_WE) begin
        we_cnt++;
        last_wd = mem_WD;
      end
      if (resp_valid) begin
        n_resp++;
        if (k_resp < 0) begin
          k_resp  = k;
          err_s   = resp_err;
          rdata_s = resp_rdata;
        end
      end
    end
    check({tag, ".latency_idx"}, k_resp, exp_k);
    check({tag, ".resp_pulses"}, n_resp, 32'd1);
    check({tag, ".err"}, {31'b0, err_s}, {31'b0, exp_err});
    check({tag, ".rdata"}, rdata_s, exp_rdata);
    check({tag, ".we_cycles"}, we_cnt, exp_wecnt);
    check({tag, ".wd"}, last_wd, exp_wd);
    check({tag, ".mem_A"}, a_or, exp_aor);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[7] = 32'h00000020;
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.ready", {31'b0, req_ready}, 32'd0);
    check("rst.resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst.mem_WE", {31'b0, mem_WE}, 32'd0);
    check("rst.mem_A", mem_A, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rst.ready_after", {31'b0, req_ready}, 32'd1);

    // Word load, word store, sub-word loads
    do_req("ldw28", 1'b0, 2'b10, 1'b0, 32'd28, 32'h0, 1, 1'b0, 32'h00000020, 0, 32'h0, 32'd28);
    do_req("stw0", 1'b1, 2'b10, 1'b0, 32'd0, 32'hDEADBEEF, 1, 1'b0, 32'h0, 1, 32'hDEADBEEF, 32'd0);
    check("stw0.mem", mem[0], 32'hDEADBEEF);
    do_req("ldb3s", 1'b0, 2'b00, 1'b0, 32'd3, 32'h0, 1, 1'b0, 32'hFFFFFFDE, 0, 32'h0, 32'd0);
    do_req("ldb3u", 1'b0, 2'b00, 1'b1, 32'd3, 32'h0, 1, 1'b0, 32'h000000DE, 0, 32'h0, 32'd0);
    do_req("ldh2s", 1'b0, 2'b01, 1'b0, 32'd2, 32'h0, 1, 1'b0, 32'hFFFFDEAD, 0, 32'h0, 32'd0);
    do_req("ldh0u", 1'b0, 2'b01, 1'b1, 32'd0, 32'h0, 1, 1'b0, 32'h0000BEEF, 0, 32'h0, 32'd0);

    // Read-modify-write byte store
    do_req("stb1", 1'b1, 2'b00, 1'b0, 32'd1, 32'hFFFFFF55, 2, 1'b0, 32'h0, 1, 32'hDEAD55EF, 32'd0);
    do_req("ldw0", 1'b0, 2'b10, 1'b0, 32'd0, 32'h0, 1, 1'b0, 32'hDEAD55EF, 0, 32'h0, 32'd0);
    do_req("sth30", 1'b1, 2'b01, 1'b0, 32'd30, 32'h00001234, 2, 1'b0, 32'h0, 1, 32'h12340020, 32'd28);

    // Errors: no memory activity
    do_req("err_h1", 1'b0, 2'b01, 1'b0, 32'd1, 32'h0, 0, 1'b1, 32'h0, 0, 32'h0, 32'd0);
    do_req("err_w2", 1'b1, 2'b10, 1'b0, 32'd2, 32'h12345678, 0, 1'b1, 32'h0, 0, 32'h0, 32'd0);
    do_req("err_sz3", 1'b0, 2'b11, 1'b0, 32'd8, 32'h0, 0, 1'b1, 32'h0, 0, 32'h0, 32'd0);
    check("err.mem0", mem[0], 32'hDEAD55EF);

    // Reset during WRITE of a byte store
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'b00;
    req_addr  = 32'd0;
    req_wdata = 32'h00000011;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstw.we_before", {31'b0, mem_WE}, 32'd1);
    rst = 1'b1;
    #1;
    check("rstw.we_drop", {31'b0, mem_WE}, 32'd0);
    check("rstw.mem_A", mem_A, 32'h0);
    @(posedge clk);
    #1;
    check("rstw.mem0", mem[0], 32'hDEAD55EF);
    check("rstw.resp_valid", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rstw.resp_valid2", {31'b0, resp_valid}, 32'd0);
    check("rstw.idle_ready", {31'b0, req_ready}, 32'd1);
    do_req("ldw0b", 1'b0, 2'b10, 1'b0, 32'd0, 32'h0, 1, 1'b0, 32'hDEAD55EF, 0, 32'h0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
